countdown_timer: RTL
====================

Name: countdown_timer

Overview:
- Down-counting companion to the team's up-counting wall clock.
- Loads an hours:minutes:seconds preset, counts down one second per `tick` strobe, and flags expiry.
- Output time fields use the same widths and ranges as the wall clock, so both can share the display path.
- Sits beside the wall clock; the top level drives `tick` from the shared 1 Hz strobe.

Parameters:
- MAX_HOURS, 23, largest legal hours value; load values above it clamp to it.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle 1 Hz strobe; counting advances only on clk edges where tick=1.
- load  input  1  capture load_* into preset and count.
- load_hours  input  5  preset hours.
- load_minutes  input  6  preset minutes.
- load_seconds  input  6  preset seconds.
- start  input  1  start or resume counting.
- pause  input  1  suspend counting.
- hours  output  5  remaining hours, 0..MAX_HOURS.
- minutes  output  6  remaining minutes, 0..59.
- seconds  output  6  remaining seconds, 0..59.
- running  output  1  high in RUN.
- expired  output  1  high in EXPIRED.
- done  output  1  one-cycle pulse when the count reaches 0:00:00.

Behaviour:
- Reset values:
  - state=IDLE.
  - hours/minutes/seconds=0; preset=0.
  - running=0, expired=0, done=0.
  - Reset mid-run aborts immediately; reset has priority over every other input.
- States: IDLE, RUN, PAUSED, EXPIRED. All outputs are registered; running/expired decode the state register.
- Priority per cycle: reset > load > start/pause > tick.
- load (any state):
  - Each field clamps independently: seconds>59→59, minutes>59→59, hours>MAX_HOURS→MAX_HOURS.
  - Clamped value is written to both preset and count.
  - Next state is IDLE; done=0.
  - tick in the same cycle is ignored.
- start:
  - IDLE/PAUSED: if count≠0 go to RUN; if count=0 stay in the current state, no done.
  - EXPIRED: count←preset; go to RUN if preset≠0, else stay EXPIRED.
  - Ignored in RUN.
- pause:
  - RUN→PAUSED; ignored in other states.
  - start and pause together: RUN→PAUSED (pause wins); PAUSED→RUN (start wins); IDLE→RUN rules as for start alone.
  - tick in the same cycle as an accepted pause is not applied.
- Decrement (RUN and tick=1, no higher-priority event):
  - seconds>0: seconds−1.
  - Else seconds←59. Then: minutes>0: minutes−1; else minutes←59 and hours−1.
  - Borrow never occurs from 0:00:00, because RUN is left on reaching zero.
- Expiry: the edge that writes 0:00:00 also sets state=EXPIRED and done=1. done is visible in the same cycle the outputs first read zero and clears the next cycle.
- tick outside RUN is ignored; the count holds.
- Latency: one clk from any accepted input to the output change.

Optional Feature:
- Macro: AUTO_RELOAD_EN.
- Defined:
  - On the expiry edge, done pulses as usual, but count←preset and state stays RUN.
  - expired never asserts from counting. preset is guaranteed ≠0 here, since RUN requires a nonzero count.
  - Outputs show the preset value immediately; 0:00:00 is never visible.
- Undefined: behaviour as above; the counter stops in EXPIRED holding 0:00:00.

Test Plan:
- Minute borrow: load 0:01:02, start, 3 ticks → 0:00:59; running=1, done=0 throughout.
- Hour borrow: load 1:00:00, start, 1 tick → 0:59:59.
- Expiry: load 0:00:02, start, 2 ticks → 0:00:00, done high exactly 1 cycle, expired=1, running=0; 5 further ticks → still 0:00:00, done=0.
- Pause/resume: load 0:00:10, start, 3 ticks → 0:00:07; pause, 4 ticks → holds 0:00:07; start, 1 tick → 0:00:06. Also assert start+pause together in RUN → PAUSED.
- Clamp, zero-start and reset:
  - Load 30:75:75 → 23:59:59.
  - Load 0:00:00 + start → stays IDLE, done=0.
  - In RUN, reset with tick=1 → all outputs 0, IDLE next cycle.
- AUTO_RELOAD_EN: load 0:00:03, start, 3 ticks → done pulse, outputs 0:00:03, running=1, expired=0; 1 more tick → 0:00:02.

Source files
------------

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Down-counting hours:minutes:seconds timer that sits beside the wall clock.
// It loads a preset, counts down one second per tick strobe and flags expiry.
// The time fields use the same widths and ranges as the wall clock, so both
// blocks can share one display path.
//
// Optional build macro: AUTO_RELOAD_EN
//   When this macro is defined, the timer reloads the preset on expiry and
//   keeps running. done still pulses, but EXPIRED is never entered from
//   counting. When it is undefined, the timer stops in EXPIRED holding 0:00:00.
//
// Ports:
//   clk           system clock; all state updates on posedge
//   reset         synchronous, active-high reset
//   tick          one-cycle 1 Hz strobe; the count advances only when tick=1
//   load          capture load_* (clamped) into preset and count
//   load_hours    preset hours   (clamped to MAX_HOURS)
//   load_minutes  preset minutes (clamped to 59)
//   load_seconds  preset seconds (clamped to 59)
//   start         start or resume counting
//   pause         suspend counting
//   hours         remaining hours, 0..MAX_HOURS
//   minutes       remaining minutes, 0..59
//   seconds       remaining seconds, 0..59
//   running       high in RUN
//   expired       high in EXPIRED
//   done          one-cycle pulse on the edge that reaches 0:00:00
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int unsigned MAX_HOURS = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [4:0] load_hours,
    input  logic [5:0] load_minutes,
    input  logic [5:0] load_seconds,
    input  logic       start,
    input  logic       pause,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       expired,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [4:0] MAX_H = 5'(MAX_HOURS);

    state_t     state_r,      state_nxt_s;
    logic [4:0] hours_r,      hours_nxt_s;
    logic [5:0] minutes_r,    minutes_nxt_s;
    logic [5:0] seconds_r,    seconds_nxt_s;
    logic [4:0] pre_hours_r,  pre_hours_nxt_s;
    logic [5:0] pre_minutes_r, pre_minutes_nxt_s;
    logic [5:0] pre_seconds_r, pre_seconds_nxt_s;
    logic       done_r,       done_nxt_s;

    logic [4:0] clamp_hours_s;
    logic [5:0] clamp_minutes_s;
    logic [5:0] clamp_seconds_s;
    logic [4:0] dec_hours_s;
    logic [5:0] dec_minutes_s;
    logic [5:0] dec_seconds_s;
    logic       count_zero_s;
    logic       preset_zero_s;
    logic       dec_zero_s;

    // Clamp each load field independently to its legal maximum.
    always_comb begin
        clamp_hours_s   = (load_hours   > MAX_H) ? MAX_H : load_hours;
        clamp_minutes_s = (load_minutes > 6'd59) ? 6'd59 : load_minutes;
        clamp_seconds_s = (load_seconds > 6'd59) ? 6'd59 : load_seconds;
    end

    // One-second decrement with borrow; never evaluated at 0:00:00 in RUN.
    always_comb begin
        dec_hours_s   = hours_r;
        dec_minutes_s = minutes_r;
        dec_seconds_s = seconds_r;
        if (seconds_r != 6'd0) begin
            dec_seconds_s = seconds_r - 6'd1;
        end else begin
            dec_seconds_s = 6'd59;
            if (minutes_r != 6'd0) begin
                dec_minutes_s = minutes_r - 6'd1;
            end else begin
                dec_minutes_s = 6'd59;
                dec_hours_s   = hours_r - 5'd1;
            end
        end
    end

    // Zero detection for the current count, the preset and the decremented count.
    always_comb begin
        count_zero_s  = (hours_r == 5'd0) && (minutes_r == 6'd0) && (seconds_r == 6'd0);
        preset_zero_s = (pre_hours_r == 5'd0) && (pre_minutes_r == 6'd0) &&
                        (pre_seconds_r == 6'd0);
        dec_zero_s    = (dec_hours_s == 5'd0) && (dec_minutes_s == 6'd0) &&
                        (dec_seconds_s == 6'd0);
    end

    // Next-state logic: load > start/pause > tick; reset is applied in the register.
    always_comb begin
        state_nxt_s       = state_r;
        hours_nxt_s       = hours_r;
        minutes_nxt_s     = minutes_r;
        seconds_nxt_s     = seconds_r;
        pre_hours_nxt_s   = pre_hours_r;
        pre_minutes_nxt_s = pre_minutes_r;
        pre_seconds_nxt_s = pre_seconds_r;
        done_nxt_s        = 1'b0;

        if (load) begin
            pre_hours_nxt_s   = clamp_hours_s;
            pre_minutes_nxt_s = clamp_minutes_s;
            pre_seconds_nxt_s = clamp_seconds_s;
            hours_nxt_s       = clamp_hours_s;
            minutes_nxt_s     = clamp_minutes_s;
            seconds_nxt_s     = clamp_seconds_s;
            state_nxt_s       = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_PAUSED: begin
                    // In PAUSED, start beats a simultaneous pause.
                    if (start && !count_zero_s) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        // Accepted pause swallows a same-cycle tick.
                        state_nxt_s = ST_PAUSED;
                    end else if (tick) begin
                        if (dec_zero_s) begin
                            done_nxt_s = 1'b1;
`ifdef AUTO_RELOAD_EN
                            // Preset is nonzero here because RUN needs a nonzero count.
                            hours_nxt_s   = pre_hours_r;
                            minutes_nxt_s = pre_minutes_r;
                            seconds_nxt_s = pre_seconds_r;
                            state_nxt_s   = ST_RUN;
`else
                            hours_nxt_s   = dec_hours_s;
                            minutes_nxt_s = dec_minutes_s;
                            seconds_nxt_s = dec_seconds_s;
                            state_nxt_s   = ST_EXPIRED;
`endif
                        end else begin
                            hours_nxt_s   = dec_hours_s;
                            minutes_nxt_s = dec_minutes_s;
                            seconds_nxt_s = dec_seconds_s;
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    // Restart from the preset; a zero preset leaves us expired.
                    if (start) begin
                        hours_nxt_s   = pre_hours_r;
                        minutes_nxt_s = pre_minutes_r;
                        seconds_nxt_s = pre_seconds_r;
                        if (!preset_zero_s) begin
                            state_nxt_s = ST_RUN;
                        end else begin
                            state_nxt_s = ST_EXPIRED;
                        end
                    end else begin
                        state_nxt_s = ST_EXPIRED;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, count, preset and done registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            hours_r       <= 5'd0;
            minutes_r     <= 6'd0;
            seconds_r     <= 6'd0;
            pre_hours_r   <= 5'd0;
            pre_minutes_r <= 6'd0;
            pre_seconds_r <= 6'd0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            hours_r       <= hours_nxt_s;
            minutes_r     <= minutes_nxt_s;
            seconds_r     <= seconds_nxt_s;
            pre_hours_r   <= pre_hours_nxt_s;
            pre_minutes_r <= pre_minutes_nxt_s;
            pre_seconds_r <= pre_seconds_nxt_s;
            done_r        <= done_nxt_s;
        end
    end

    assign hours   = hours_r;
    assign minutes = minutes_r;
    assign seconds = seconds_r;
    assign running = (state_r == ST_RUN);
    assign expired = (state_r == ST_EXPIRED);
    assign done    = done_r;

endmodule
